// File: rtl/fir16_pkg.sv
// Shared parameters and state encoding for the fir16 feeder/MAC datapath.
package fir16_pkg;

  localparam int DATA_W      = 16;
  localparam int TAPS        = 16;
  localparam int MAC_LAT     = 2;
  localparam int ACC_W       = 36;
  localparam int ADDR_W      = $clog2(TAPS);
  localparam int CNT_W       = $clog2(TAPS + 1);
  localparam int FLUSH_CNT_W = $clog2(MAC_LAT + 1);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/fir16_coef_bank.sv
// Shadow/active coefficient register files; commit copies the whole shadow bank,
// including a write that lands on the same edge.
module fir16_coef_bank
  import fir16_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic [DATA_W-1:0]        coef_wdata,
  input  logic                     coef_commit,
  output logic [TAPS*DATA_W-1:0]   coeffs_flat
);

  logic [DATA_W-1:0] r_shadow [TAPS];
  logic [DATA_W-1:0] r_active [TAPS];

  // NOTE: both banks are reset because coeffs_flat must read 0 straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        if (coef_we && (coef_addr == ADDR_W'(i)))
          r_shadow[i] <= coef_wdata;
        if (coef_commit)
          r_active[i] <= (coef_we && (coef_addr == ADDR_W'(i))) ? coef_wdata : r_shadow[i];
      end
    end
  end

  for (genvar g = 0; g < TAPS; g++) begin : g_flat
    assign coeffs_flat[DATA_W*g +: DATA_W] = r_active[g];
  end

endmodule

// File: rtl/fir16_tap_feeder.sv
// Delay line, fill counter, FILL/RUN/FLUSH sequencing and y_valid tag pipeline
// feeding fir16_mac_core.
module fir16_tap_feeder
  import fir16_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic                     flush,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic [DATA_W-1:0]        coef_wdata,
  input  logic                     coef_commit,
  output logic [TAPS*DATA_W-1:0]   samples_flat,
  output logic [TAPS*DATA_W-1:0]   coeffs_flat,
  output logic                     window_full,
  output logic                     y_valid
);

  logic [DATA_W-1:0]      r_win [TAPS];
  logic [CNT_W-1:0]       r_fill_cnt;
  logic [1:0]             r_state;
  logic [FLUSH_CNT_W-1:0] r_flush_cnt;
  logic                   r_rdy_q;
  logic                   r_window_full;
  logic [MAC_LAT:0]       r_tag;
  logic                   w_accept;
  logic                   w_full_after;

  assign sample_ready = r_rdy_q & ~flush;
  assign w_accept     = sample_valid & sample_ready;
  assign w_full_after = (r_fill_cnt >= CNT_W'(TAPS - 1));
  assign window_full  = r_window_full;
  // tag0 is set on the shift edge, so MAC_LAT further stages line up with y_out.
  assign y_valid      = r_tag[MAC_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_FILL;
      r_flush_cnt <= '0;
      r_rdy_q     <= 1'b0;
    end else if (flush) begin
      r_state     <= ST_FLUSH;
      r_flush_cnt <= '0;
      r_rdy_q     <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          r_rdy_q <= 1'b1;
          if (w_accept && w_full_after) r_state <= ST_RUN;
        end
        ST_RUN: r_rdy_q <= 1'b1;
        ST_FLUSH: begin
          if (r_flush_cnt == FLUSH_CNT_W'(MAC_LAT - 1)) begin
            r_state <= ST_FILL;
            r_rdy_q <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_FILL;
          r_rdy_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) r_win[i] <= '0;
      r_fill_cnt    <= '0;
      r_window_full <= 1'b0;
      r_tag         <= '0;
    end else if (flush) begin
      for (int i = 0; i < TAPS; i++) r_win[i] <= '0;
      r_fill_cnt    <= '0;
      r_window_full <= 1'b0;
      r_tag         <= '0;
    end else begin
      r_tag <= {r_tag[MAC_LAT-1:0], w_accept & w_full_after};
      if (w_accept) begin
        // NOTE: non-blocking assignments make this shift independent of loop order.
        for (int i = TAPS - 1; i > 0; i--) r_win[i] <= r_win[i-1];
        r_win[0] <= sample_in;
        if (r_fill_cnt != CNT_W'(TAPS)) r_fill_cnt <= r_fill_cnt + 1'b1;
        r_window_full <= w_full_after;
      end
    end
  end

  for (genvar g = 0; g < TAPS; g++) begin : g_flat
    assign samples_flat[DATA_W*g +: DATA_W] = r_win[g];
  end

  fir16_coef_bank u_coef_bank (
    .clk         (clk),
    .reset       (reset),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
    .coef_commit (coef_commit),
    .coeffs_flat (coeffs_flat)
  );

endmodule
